// File: rtl/mac_acc_stage.sv
// Accumulator stage of the low-power MAC: sums framed signed products with
// saturation and hands one result per frame to the consumer via valid/ready.
module mac_acc_stage #(
    parameter int IN_W  = 24,
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                  state, state_nxt;
    logic signed [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0]        count, count_nxt;
    logic                    ovf, ovf_nxt;
    logic                    accept, start;
    logic signed [ACC_W:0]   base, ext, sum;

    function automatic logic signed [ACC_W-1:0] saturate(input logic signed [ACC_W:0] s);
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
    endfunction

    function automatic logic sat_hit(input logic signed [ACC_W:0] s);
        return s[ACC_W] ^ s[ACC_W-1];
    endfunction

    // A term arriving with no open frame starts one even without in_first.
    assign accept = in_valid && in_ready && !clear;
    assign start  = in_first || (state == IDLE);

    always_comb begin
        ext       = {{(ACC_W+1-IN_W){in_data[IN_W-1]}}, in_data};
        base      = start ? '0 : {acc[ACC_W-1], acc};
        sum       = base + ext;
        acc_nxt   = saturate(sum);
        ovf_nxt   = (start ? 1'b0 : ovf) | sat_hit(sum);
        count_nxt = start ? CNT_W'(1) : ((&count) ? count : count + CNT_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, ACCUM: if (accept) state_nxt = in_last ? HOLD : ACCUM;
                HOLD:        if (out_ready) state_nxt = IDLE;
                default:     state_nxt = IDLE;
            endcase
        end
    end

    // Handshake flags decode the state only, so in_ready never depends on out_ready.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        case (state)
            HOLD:    begin in_ready = 1'b0; out_valid = 1'b1; end
            default: begin in_ready = 1'b1; out_valid = 1'b0; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_count <= '0;
        end else if (clear) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (accept) begin
            acc   <= acc_nxt;
            count <= count_nxt;
            ovf   <= ovf_nxt;
            if (in_last) begin
                out_data  <= acc_nxt;
                out_ovf   <= ovf_nxt;
                out_count <= count_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mac_acc_stage.sv
// Scoreboard bench for mac_acc_stage: a frame-level reference model predicts
// each result, and an independent monitor pops and compares on output transfers.
module tb_mac_acc_stage;
    localparam int IN_W  = 24;
    localparam int ACC_W = 32;
    localparam int CNT_W = 8;
    localparam longint MAXP = 64'sd2147483647;
    localparam longint MAXN = -64'sd2147483648;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_data = '0;
    logic             in_first = 1'b0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;
    logic [CNT_W-1:0] out_count;

    mac_acc_stage #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .out_count(out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ACC_W-1:0] data;
        logic             ovf;
        logic [CNT_W-1:0] count;
    } result_t;

    result_t sb[$];
    int      terms[$];
    bit      open = 0;
    int      vectors = 0;
    int      miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame model: replay the collected terms with per-term clamping.
    task automatic model_accept(input int d, input bit f, input bit l);
        longint  s;
        bit      o;
        result_t r;
        if (f || !open) begin
            terms.delete();
            open = 1;
        end
        terms.push_back(d);
        if (l) begin
            s = 0;
            o = 0;
            foreach (terms[i]) begin
                s = s + longint'(terms[i]);
                if (s > MAXP) begin s = MAXP; o = 1; end
                else if (s < MAXN) begin s = MAXN; o = 1; end
            end
            r.data  = s[ACC_W-1:0];
            r.ovf   = o;
            r.count = (terms.size() > 255) ? 8'd255 : 8'(terms.size());
            sb.push_back(r);
            open = 0;
        end
    endtask

    task automatic model_drop();
        terms.delete();
        open = 0;
    endtask

    task automatic send(input int d, input bit f, input bit l, input bit rnd, output int waits);
        bit ok;
        logic [31:0] dv;
        dv = d;
        waits = 0;
        ok = 0;
        in_data  = dv[IN_W-1:0];
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        forever begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready && !clear) begin ok = 1; break; end
            waits++;
            if (waits > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_timeout: in_ready stuck at %0b, required 1", in_ready);
                break;
            end
            @(posedge clk); #1;
        end
        if (ok) model_accept(d, f, l);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    // Monitor: every output transfer pops one predicted result.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !clear) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 64'(out_valid), 64'd0);
            end else begin
                result_t r;
                r = sb.pop_front();
                check("out_data",  64'(out_data),  64'(r.data));
                check("out_ovf",   64'(out_ovf),   64'(r.ovf));
                check("out_count", 64'(out_count), 64'(r.count));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        logic signed [IN_W-1:0] r;
        int len;
        bit f;

        #3 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_ovf",   64'(out_ovf),   64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Basic sum with one-cycle latency to out_valid.
        send(5, 1, 0, 0, w);
        send(-2, 0, 0, 0, w);
        send(10, 0, 1, 0, w);
        check("latency_out_valid", 64'(out_valid), 64'd1);
        cycles(2);

        // Positive saturation then a clean single-term frame.
        for (int i = 0; i < 300; i++) send(32'h7FFFFF, i == 0, i == 299, 0, w);
        send(1, 1, 1, 0, w);
        cycles(2);

        // Backpressure on a single-term frame.
        out_ready = 1'b0;
        send(-7, 1, 1, 0, w);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_data",  64'(out_data),  64'hFFFFFFF9);
            check("bp_in_ready",  64'(in_ready),  64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(3, 1, 1, 0, w);
        check("bp_accept_wait", 64'(w), 64'd1);
        cycles(2);

        // Restart mid-frame, then negative saturation.
        send(100, 1, 0, 0, w);
        send(200, 0, 0, 0, w);
        send(7, 1, 0, 0, w);
        send(1, 0, 1, 0, w);
        cycles(2);
        for (int i = 0; i < 260; i++) send(-32'sh800000, i == 0, i == 259, 0, w);
        cycles(2);

        // Implicit frame start from IDLE.
        send(4, 0, 0, 0, w);
        send(6, 0, 1, 0, w);
        cycles(2);

        // Clear in ACCUM; the concurrent last term must be ignored.
        send(50, 1, 0, 0, w);
        send(60, 0, 0, 0, w);
        clear = 1'b1;
        in_valid = 1'b1; in_data = 24'd999; in_last = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        in_valid = 1'b0; in_last = 1'b0;
        model_drop();
        @(negedge clk);
        check("clr_out_valid", 64'(out_valid), 64'd0);
        check("clr_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk); #1;
        send(9, 0, 0, 0, w);
        send(1, 0, 1, 0, w);
        cycles(2);

        // Asynchronous reset while holding a result.
        out_ready = 1'b0;
        send(20, 1, 1, 0, w);
        check("hold_out_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        sb.delete();
        model_drop();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(9, 1, 0, 0, w);
        send(1, 0, 1, 0, w);
        cycles(2);

        // Random frames with random consumer backpressure.
        for (int k = 0; k < 40; k++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                r = IN_W'($urandom);
                if (i == 0) f = ($urandom_range(0, 3) != 0);
                else        f = ($urandom_range(0, 7) == 0);
                send(int'(r), f, i == len - 1, 1, w);
            end
            if ($urandom_range(0, 1) == 1) cycles($urandom_range(1, 3));
        end
        out_ready = 1'b1;
        cycles(5);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
